// File: rtl/dma_pkg.sv
// Shared definitions for the dma_copy block-copy engine: register offsets,
// CTRL/STATUS bit positions and the transfer state encoding.
package dma_pkg;

  localparam logic [3:0] SRC_OFF  = 4'h0;
  localparam logic [3:0] DST_OFF  = 4'h4;
  localparam logic [3:0] LEN_OFF  = 4'h8;
  localparam logic [3:0] CTRL_OFF = 4'hC;

  localparam int CTRL_START  = 0;
  localparam int CTRL_BUSY   = 1;
  localparam int CTRL_DONE   = 2;
  localparam int CTRL_ERR    = 3;
  localparam int CTRL_ABORT  = 4;
  localparam int CTRL_IRQ_EN = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } dma_state_t;

  // Byte-lane merge of a config write into an existing 32-bit register value.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  mask);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*8 +: 8] = mask[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dma_copy.sv
// Single-channel word-copy DMA: config responder port plus bus initiator.
// Define DMA_COPY_IRQ_EN to enable the level completion interrupt on irq_out.
module dma_copy
  import dma_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic        ready_out,
  output logic [31:0] address_out,
  output logic        read_out,
  output logic        write_out,
  input  logic [31:0] read_value_in,
  output logic [3:0]  write_mask_out,
  output logic [31:0] write_value_out,
  input  logic        ready_in,
  input  logic        fault_in,
  output logic        irq_out
);

  dma_state_t           state_q, state_d;
  logic [31:0]          src_q, src_d;
  logic [31:0]          dst_q, dst_d;
  logic [31:0]          buf_q, buf_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 abort_pend_q, abort_pend_d;
  logic                 irq_en_q, irq_en_d;

  logic [3:0] reg_off;
  logic       busy;
  logic       cfg_wr;
  logic       ctrl_wr;
  logic       start_req;
  logic       abort_req;
  logic       unused_cfg;

  assign reg_off   = {address_in[3:2], 2'b00};
  assign busy      = (state_q != IDLE);
  assign cfg_wr    = sel_in & (|write_mask_in);
  assign ctrl_wr   = cfg_wr & (reg_off == CTRL_OFF) & write_mask_in[0];
  // ABORT in the same write as START suppresses the START.
  assign start_req = ctrl_wr & write_value_in[CTRL_START] & ~write_value_in[CTRL_ABORT];
  assign abort_req = ctrl_wr & write_value_in[CTRL_ABORT];

  assign unused_cfg = &{1'b0, read_in, address_in[31:4], address_in[1:0]};

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    buf_d        = buf_q;
    len_d        = len_q;
    done_d       = done_q;
    err_d        = err_q;
    abort_pend_d = abort_pend_q;
    irq_en_d     = irq_en_q;

    if (!busy && cfg_wr) begin
      case (reg_off)
        SRC_OFF: src_d = merge_bytes(src_q, write_value_in, write_mask_in) & ~32'h3;
        DST_OFF: dst_d = merge_bytes(dst_q, write_value_in, write_mask_in) & ~32'h3;
        LEN_OFF: len_d = LEN_WIDTH'(merge_bytes(32'(len_q), write_value_in, write_mask_in));
        default: ;
      endcase
    end

    // W1C first so that a status-setting event in the same cycle wins.
    if (ctrl_wr) begin
      if (write_value_in[CTRL_DONE]) done_d = 1'b0;
      if (write_value_in[CTRL_ERR])  err_d  = 1'b0;
`ifdef DMA_COPY_IRQ_EN
      irq_en_d = write_value_in[CTRL_IRQ_EN];
`endif
    end

    if (busy && abort_req) abort_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        abort_pend_d = 1'b0;
        if (start_req) begin
          err_d = 1'b0;
          if (len_q != '0) begin
            done_d  = 1'b0;
            state_d = RD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RD: begin
        if (ready_in) begin
          if (fault_in) begin
            state_d      = IDLE;
            err_d        = 1'b1;
            done_d       = 1'b0;
            abort_pend_d = 1'b0;
          end else begin
            buf_d   = read_value_in;
            src_d   = src_q + 32'd4;
            state_d = WR;
          end
        end
      end
      WR: begin
        if (ready_in) begin
          if (fault_in) begin
            state_d      = IDLE;
            err_d        = 1'b1;
            done_d       = 1'b0;
            abort_pend_d = 1'b0;
          end else begin
            dst_d = dst_q + 32'd4;
            len_d = len_q - LEN_WIDTH'(1);
            if (len_q == LEN_WIDTH'(1) || abort_pend_q || abort_req) begin
              state_d      = IDLE;
              done_d       = 1'b1;
              abort_pend_d = 1'b0;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      buf_q        <= '0;
      len_q        <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      abort_pend_q <= 1'b0;
      irq_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      buf_q        <= buf_d;
      len_q        <= len_d;
      done_q       <= done_d;
      err_q        <= err_d;
      abort_pend_q <= abort_pend_d;
      irq_en_q     <= irq_en_d;
    end
  end

  // Bus requests decode straight from flops, so they hold steady until ready_in.
  assign read_out        = (state_q == RD);
  assign write_out       = (state_q == WR);
  assign address_out     = read_out ? src_q : (write_out ? dst_q : 32'h0);
  assign write_mask_out  = write_out ? 4'hF : 4'h0;
  assign write_value_out = write_out ? buf_q : 32'h0;
  assign ready_out       = sel_in;

  always_comb begin
    read_value_out = 32'h0;
    if (sel_in) begin
      case (reg_off)
        SRC_OFF: read_value_out = src_q;
        DST_OFF: read_value_out = dst_q;
        LEN_OFF: read_value_out = 32'(len_q);
        default: begin
          read_value_out[CTRL_BUSY]   = busy;
          read_value_out[CTRL_DONE]   = done_q;
          read_value_out[CTRL_ERR]    = err_q;
          read_value_out[CTRL_IRQ_EN] = irq_en_q;
        end
      endcase
    end
  end

`ifdef DMA_COPY_IRQ_EN
  assign irq_out = (done_q | err_q) & irq_en_q;
`else
  assign irq_out = 1'b0;
`endif

endmodule

// File: tb/tb_dma_copy.sv
// Directed bench for dma_copy: register table plus bus-level copy sequences.
module tb_dma_copy;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic        ready_out;
  logic [31:0] address_out;
  logic        read_out;
  logic        write_out;
  logic [31:0] read_value_in;
  logic [3:0]  write_mask_out;
  logic [31:0] write_value_out;
  logic        ready_in;
  logic        fault_in;
  logic        irq_out;

  dma_copy #(.LEN_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .address_in(address_in), .sel_in(sel_in), .read_in(read_in),
    .read_value_out(read_value_out), .write_mask_in(write_mask_in),
    .write_value_in(write_value_in), .ready_out(ready_out),
    .address_out(address_out), .read_out(read_out), .write_out(write_out),
    .read_value_in(read_value_in), .write_mask_out(write_mask_out),
    .write_value_out(write_value_out), .ready_in(ready_in),
    .fault_in(fault_in), .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Responder model state
  logic [31:0] mem [logic [31:0]];
  int          wait_states = 0;
  int          fault_read  = 0;
  int          rd_beats    = 0;
  int          req_cycles  = 0;
  int          proto_err   = 0;
  bit          beat_we[$];
  logic [31:0] beat_addr[$];
  logic [31:0] beat_data[$];

  typedef struct {
    bit          is_wr;
    logic [3:0]  off;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] exp;
    string       name;
  } cfg_vec_t;
  cfg_vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic fill(input logic [31:0] base, input int n, input logic [31:0] seed);
    for (int i = 0; i < n; i++) mem[base + 32'(4*i)] = seed + 32'(i);
  endtask

  task automatic clear_log();
    beat_we.delete(); beat_addr.delete(); beat_data.delete();
    rd_beats = 0; req_cycles = 0;
  endtask

  task automatic add_vec(input bit w, input logic [3:0] off, input logic [31:0] d,
                         input logic [3:0] m, input logic [31:0] e, input string nm);
    cfg_vec_t v;
    v.is_wr = w; v.off = off; v.data = d; v.mask = m; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic cfg_write(input logic [3:0] off, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    address_in = 32'h0004_0000 | 32'(off);
    sel_in = 1'b1; write_mask_in = m; write_value_in = d;
    @(posedge clk);
    #1;
    sel_in = 1'b0; write_mask_in = 4'h0; write_value_in = 32'h0;
  endtask

  task automatic cfg_read(input logic [3:0] off, output logic [31:0] v);
    @(negedge clk);
    address_in = 32'h0004_0000 | 32'(off);
    sel_in = 1'b1; read_in = 1'b1;
    #1;
    v = read_value_out;
    sel_in = 1'b0; read_in = 1'b0;
  endtask

  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
    cfg_write(4'h0, s, 4'hF);
    cfg_write(4'h4, d, 4'hF);
    cfg_write(4'h8, n, 4'hF);
    cfg_write(4'hC, 32'h1, 4'hF);
  endtask

  task automatic wait_idle(input string nm);
    logic [31:0] v;
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      cfg_read(4'hC, v);
      if (!v[1]) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: busy still %0d, required 0", nm, v[1]);
    end
  endtask

  // Bus responder: zero or more wait states, optional fault on the Nth read.
  initial begin : responder
    int          wcnt;
    bit          have_prev, is_fault;
    logic [31:0] p_addr, p_wd;
    logic        p_rd, p_wr;
    wcnt = 0; have_prev = 1'b0;
    p_addr = '0; p_wd = '0; p_rd = 1'b0; p_wr = 1'b0;
    ready_in = 1'b0; fault_in = 1'b0; read_value_in = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        ready_in = 1'b0; fault_in = 1'b0; wcnt = 0; have_prev = 1'b0;
        continue;
      end
      if (read_out && write_out) proto_err++;
      if (write_mask_out !== (write_out ? 4'hF : 4'h0)) proto_err++;
      if (have_prev && (read_out || write_out)) begin
        if (address_out !== p_addr || read_out !== p_rd || write_out !== p_wr ||
            write_value_out !== p_wd) proto_err++;
      end
      if (read_out || write_out) req_cycles++;
      if ((read_out || write_out) && wcnt == wait_states) begin
        is_fault = read_out && (fault_read != 0) && (rd_beats + 1 == fault_read);
        ready_in = 1'b1;
        fault_in = is_fault;
        beat_we.push_back(write_out);
        beat_addr.push_back(address_out);
        if (read_out) begin
          read_value_in = mem_rd(address_out);
          rd_beats++;
          beat_data.push_back(read_value_in);
        end else begin
          if (!is_fault) mem[address_out] = write_value_out;
          beat_data.push_back(write_value_out);
        end
        wcnt = 0; have_prev = 1'b0;
      end else begin
        ready_in = 1'b0; fault_in = 1'b0;
        if (read_out || write_out) begin
          wcnt++; have_prev = 1'b1;
          p_addr = address_out; p_wd = write_value_out; p_rd = read_out; p_wr = write_out;
        end else begin
          wcnt = 0; have_prev = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin : main
    logic [31:0] v;
    bit          found;

    reset = 1'b1;
    address_in = '0; sel_in = 1'b0; read_in = 1'b0;
    write_mask_in = '0; write_value_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {address_out, read_out, write_out, write_mask_out,
                          write_value_out[0], irq_out}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Register table: reset values, masking, alignment, W1C, START/ABORT corners.
    add_vec(0, 4'h0, 0, 0, 32'h0, "rst_src");
    add_vec(0, 4'h4, 0, 0, 32'h0, "rst_dst");
    add_vec(0, 4'h8, 0, 0, 32'h0, "rst_len");
    add_vec(0, 4'hC, 0, 0, 32'h0, "rst_ctrl");
    add_vec(1, 4'h0, 32'h1234_5677, 4'hF, 0, "");
    add_vec(0, 4'h0, 0, 0, 32'h1234_5674, "src_align");
    add_vec(1, 4'h0, 32'hFFFF_FF00, 4'b0010, 0, "");
    add_vec(0, 4'h0, 0, 0, 32'h1234_FF74, "src_bytemask");
    add_vec(1, 4'h4, 32'hCAFE_BABF, 4'hF, 0, "");
    add_vec(0, 4'h4, 0, 0, 32'hCAFE_BABC, "dst_align");
    add_vec(1, 4'h8, 32'hFFFF_1234, 4'hF, 0, "");
    add_vec(0, 4'h8, 0, 0, 32'h0000_1234, "len_zext");
    add_vec(1, 4'h8, 32'h0, 4'h0, 0, "");
    add_vec(0, 4'h8, 0, 0, 32'h0000_1234, "len_nomask");
    add_vec(1, 4'h8, 32'h0, 4'hF, 0, "");
    add_vec(1, 4'hC, 32'h1, 4'hF, 0, "");
    add_vec(0, 4'hC, 0, 0, 32'h0000_0004, "start_len0_done");
    add_vec(1, 4'hC, 32'h4, 4'hF, 0, "");
    add_vec(0, 4'hC, 0, 0, 32'h0, "done_w1c");
    add_vec(1, 4'hC, 32'h10, 4'hF, 0, "");
    add_vec(0, 4'hC, 0, 0, 32'h0, "abort_idle");
    add_vec(1, 4'hC, 32'h11, 4'hF, 0, "");
    add_vec(0, 4'hC, 0, 0, 32'h0, "start_abort_same");

    clear_log();
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_wr) cfg_write(vecs[i].off, vecs[i].data, vecs[i].mask);
      else begin
        cfg_read(vecs[i].off, v);
        check(vecs[i].name, v, vecs[i].exp);
      end
    end
    check("len0_no_bus", 32'(req_cycles), 32'd0);

    @(negedge clk);
    address_in = 32'h0004_0000; sel_in = 1'b0;
    #1;
    check("unsel_read_zero", read_value_out, 32'h0);
    check("ready_eq_sel", {31'h0, ready_out}, 32'h0);
    sel_in = 1'b1;
    #1;
    check("ready_eq_sel_hi", {31'h0, ready_out}, 32'h1);
    sel_in = 1'b0;

    // Zero-wait copy of 4 words: exactly 8 cycles.
    fill(32'h100, 8, 32'hA5A5_0000);
    wait_states = 0;
    clear_log();
    start_copy(32'h100, 32'h200, 32'd4);
    repeat (7) @(posedge clk);
    cfg_read(4'hC, v);
    check("copy4_busy_c7", v, 32'h2);
    @(posedge clk);
    cfg_read(4'hC, v);
    check("copy4_done_c8", v, 32'h4);
    check("copy4_beats", 32'(beat_addr.size()), 32'd8);
    for (int k = 0; k < 8 && k < beat_addr.size(); k++) begin
      check($sformatf("copy4_beat%0d_addr", k), beat_addr[k],
            ((k % 2) ? 32'h200 : 32'h100) + 32'(4 * (k / 2)));
      check($sformatf("copy4_beat%0d_we", k), {31'h0, beat_we[k]}, 32'(k % 2));
      check($sformatf("copy4_beat%0d_data", k), beat_data[k], 32'hA5A5_0000 + 32'(k / 2));
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("copy4_mem%0d", i), mem_rd(32'h200 + 32'(4*i)), 32'hA5A5_0000 + 32'(i));
    cfg_read(4'h0, v); check("copy4_src", v, 32'h110);
    cfg_read(4'h4, v); check("copy4_dst", v, 32'h210);
    cfg_read(4'h8, v); check("copy4_len", v, 32'h0);

    // Three wait states per beat: 32 cycles, stable requests.
    wait_states = 3;
    proto_err = 0;
    clear_log();
    start_copy(32'h100, 32'h500, 32'd4);
    repeat (31) @(posedge clk);
    cfg_read(4'hC, v);
    check("wait3_busy_c31", v, 32'h2);
    @(posedge clk);
    cfg_read(4'hC, v);
    check("wait3_done_c32", v, 32'h4);
    check("wait3_stable", 32'(proto_err), 32'd0);
    for (int i = 0; i < 4; i++)
      check($sformatf("wait3_mem%0d", i), mem_rd(32'h500 + 32'(4*i)), 32'hA5A5_0000 + 32'(i));

    // Fault on the second read.
    wait_states = 0;
    fault_read = 2;
    clear_log();
    start_copy(32'h100, 32'h600, 32'd4);
    wait_idle("fault");
    repeat (10) @(posedge clk);
    fault_read = 0;
    cfg_read(4'hC, v); check("fault_ctrl", v, 32'h8);
    cfg_read(4'h0, v); check("fault_src", v, 32'h104);
    cfg_read(4'h4, v); check("fault_dst", v, 32'h604);
    cfg_read(4'h8, v); check("fault_len", v, 32'h3);
    check("fault_beats", 32'(beat_addr.size()), 32'd3);

    // ABORT during the read of word 2 of 5.
    fill(32'h300, 5, 32'h5A5A_0000);
    wait_states = 3;
    clear_log();
    start_copy(32'h300, 32'h700, 32'd5);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (read_out && beat_addr.size() == 2) begin found = 1'b1; break; end
    end
    check("abort_reach_rd2", {31'h0, found}, 32'h1);
    cfg_write(4'hC, 32'h10, 4'hF);
    wait_idle("abort");
    cfg_read(4'hC, v); check("abort_ctrl", v, 32'h4);
    cfg_read(4'h8, v); check("abort_len", v, 32'h3);
    cfg_read(4'h0, v); check("abort_src", v, 32'h308);
    check("abort_beats", 32'(beat_addr.size()), 32'd4);
    check("abort_mem1", mem_rd(32'h704), 32'h5A5A_0001);

    // DST write while busy is ignored.
    clear_log();
    start_copy(32'h100, 32'h800, 32'd2);
    cfg_write(4'h4, 32'hDEAD_0000, 4'hF);
    wait_idle("dstbusy");
    cfg_read(4'h4, v); check("dstbusy_dst", v, 32'h808);
    check("dstbusy_mem1", mem_rd(32'h804), 32'hA5A5_0001);
    check("dstbusy_beats", 32'(beat_addr.size()), 32'd4);

    // Interrupt behaviour depends on the build.
    wait_states = 0;
`ifdef DMA_COPY_IRQ_EN
    cfg_write(4'hC, 32'h2C, 4'hF);
    #1 check("irq_low_before", {31'h0, irq_out}, 32'h0);
    start_copy(32'h100, 32'hA00, 32'd1);
    wait_idle("irq");
    check("irq_high_done", {31'h0, irq_out}, 32'h1);
    cfg_write(4'hC, 32'h24, 4'hF);
    check("irq_low_w1c", {31'h0, irq_out}, 32'h0);
    cfg_read(4'hC, v); check("irq_ctrl", v, 32'h20);
`else
    cfg_write(4'hC, 32'h2C, 4'hF);
    cfg_read(4'hC, v); check("irqen_reads0", v, 32'h0);
    start_copy(32'h100, 32'hA00, 32'd1);
    wait_idle("irq");
    check("irq_tied0", {31'h0, irq_out}, 32'h0);
    cfg_read(4'hC, v); check("irq_ctrl", v, 32'h4);
`endif

    // Asynchronous reset in the middle of a write beat.
    wait_states = 3;
    clear_log();
    start_copy(32'h100, 32'h900, 32'd3);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (write_out) begin found = 1'b1; break; end
    end
    check("arst_reach_wr", {31'h0, found}, 32'h1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_addr", address_out, 32'h0);
    check("arst_req", {30'h0, read_out, write_out}, 32'h0);
    check("arst_wmask", {28'h0, write_mask_out}, 32'h0);
    check("arst_wdata", write_value_out, 32'h0);
    check("arst_irq", {31'h0, irq_out}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cfg_read(4'h0, v); check("arst_src", v, 32'h0);
    cfg_read(4'hC, v); check("arst_ctrl", v, 32'h0);
    check("protocol_overall", 32'(proto_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
